uart_rxfifo: RTL

Receive buffer between the UART receiver core and the CPU-facing UART port register file. It accepts received bytes and their frame-error flags over an AXI-stream style input. It holds them in a DEPTH-entry first-word-fall-through FIFO and presents the head byte to the port logic. It also raises a fill-threshold interrupt and an idle-timeout interrupt, and records overruns in a sticky flag, so the CPU can service the UART in bursts instead of per byte.

---
 rtl/uart_rxfifo_if.sv | 31 +++
 rtl/uart_rxfifo.sv | 105 ++++++++++
 2 files changed

// File: rtl/uart_rxfifo_if.sv
// Bundle between the UART receiver core / port register file and the receive FIFO.
interface uart_rxfifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [7:0]          s_tdata;
  logic                s_tfe;
  logic                s_tvalid;
  logic                s_tready;
  logic                rd;
  logic                clr;
  logic                ovr_clr;
  logic [DEPTH_LOG2:0] threshold;
  logic [7:0]          dout;
  logic                dout_fe;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overrun;
  logic                thr_irq;
  logic                tmo_irq;

  modport master (
    output s_tdata, s_tfe, s_tvalid, rd, clr, ovr_clr, threshold,
    input  s_tready, dout, dout_fe, empty, full, level, overrun, thr_irq, tmo_irq
  );

  modport slave (
    input  s_tdata, s_tfe, s_tvalid, rd, clr, ovr_clr, threshold,
    output s_tready, dout, dout_fe, empty, full, level, overrun, thr_irq, tmo_irq
  );
endinterface

// File: rtl/uart_rxfifo.sv
// UART receive FIFO: FWFT byte buffer with frame-error tags, sticky overrun,
// fill-threshold and idle-timeout interrupts.
module uart_rxfifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic          clk,
  input logic          rst_n,
  uart_rxfifo_if.slave bus
);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned TcW   = $clog2(TIMEOUT + 1);

  localparam logic [DEPTH_LOG2:0]   CntFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CntZero = '0;
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
  localparam logic [TcW-1:0]        TcMax   = TcW'(TIMEOUT);
  localparam logic [TcW-1:0]        TcOne   = TcW'(1);

  logic [8:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp, w_wp_d, w_rp_d;
  logic [DEPTH_LOG2:0]   r_cnt, w_cnt_d;
  logic [TcW-1:0]        r_tc, w_tc_d;
  logic                  r_ovr, w_ovr_d;
  logic                  r_thr, w_thr_d;
  logic                  r_tmo, w_tmo_d;
  logic                  r_ready;

  logic w_empty, w_full, w_pop, w_push, w_drop, w_act;

  assign w_empty = (r_cnt == CntZero);
  assign w_full  = (r_cnt == CntFull);
  assign w_pop   = bus.rd & ~w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_push  = bus.s_tvalid & (~w_full | w_pop);
  assign w_drop  = bus.s_tvalid & w_full & ~w_pop;
  assign w_act   = w_push | w_pop | bus.clr;

  always_comb begin
    w_wp_d  = r_wp;
    w_rp_d  = r_rp;
    w_cnt_d = r_cnt;
    w_ovr_d = r_ovr;
    w_tc_d  = r_tc;

    if (bus.clr) begin
      w_wp_d  = '0;
      w_rp_d  = '0;
      w_cnt_d = '0;
    end else begin
      if (w_push) w_wp_d = r_wp + PtrOne;
      if (w_pop)  w_rp_d = r_rp + PtrOne;
      if (w_push && !w_pop)      w_cnt_d = r_cnt + CntOne;
      else if (w_pop && !w_push) w_cnt_d = r_cnt - CntOne;
    end

    // Set wins over clear; a flush discards the incoming byte without flagging it.
    if (w_drop && !bus.clr) w_ovr_d = 1'b1;
    else if (bus.ovr_clr)   w_ovr_d = 1'b0;

    if (w_act || w_empty)  w_tc_d = '0;
    else if (r_tc != TcMax) w_tc_d = r_tc + TcOne;

    w_tmo_d = (r_tc == TcMax) & ~w_empty & ~w_act;
    w_thr_d = (bus.threshold != CntZero) & (w_cnt_d >= bus.threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tc    <= '0;
      r_ovr   <= 1'b0;
      r_thr   <= 1'b0;
      r_tmo   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_wp    <= w_wp_d;
      r_rp    <= w_rp_d;
      r_cnt   <= w_cnt_d;
      r_tc    <= w_tc_d;
      r_ovr   <= w_ovr_d;
      r_thr   <= w_thr_d;
      r_tmo   <= w_tmo_d;
      r_ready <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !bus.clr) r_mem[r_wp] <= {bus.s_tfe, bus.s_tdata};
  end

  assign bus.s_tready = r_ready;
  assign bus.dout     = r_mem[r_rp][7:0];
  assign bus.dout_fe  = r_mem[r_rp][8];
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.level    = r_cnt;
  assign bus.overrun  = r_ovr;
  assign bus.thr_irq  = r_thr;
  assign bus.tmo_irq  = r_tmo;
endmodule
